pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// pc_sequencer
// Program-counter sequencer for a simple in-order fetch stage.
// It steps the fetch address sequentially, redirects on taken branches and
// jumps (followed by a programmable bubble window), and parks in a sticky
// HALT state on request. Every output comes straight from a flop.

module pc_sequencer #(
  parameter int                ADDR_W       = 20,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = 1     // legal range 1..3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush,
  output logic              halted,
  output logic [15:0]       taken_count
);

  // The bubble counter holds "remaining bubbles minus one", so a redirect
  // loads FLUSH_CYCLES-1 and the window closes on the edge that sees zero.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_pc_valid;
  logic                r_flush;
  logic                r_halted;
  logic [15:0]         r_taken_count;
  logic [1:0]          r_flush_cnt;

  // A taken conditional branch outranks a jump resolving in the same cycle.
  logic                w_br_redirect;
  logic                w_redirect;
  logic [ADDR_W-1:0]   w_redirect_target;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [15:0]         w_count_next;

  assign w_br_redirect     = br_valid & br_taken;
  assign w_redirect        = w_br_redirect | jmp_valid;
  assign w_redirect_target = w_br_redirect ? br_target : jmp_target;

  // Sequential step wraps naturally from all-ones to zero.
  assign w_pc_inc          = r_pc + ADDR_W'(1);

  // Redirect counter sticks at all-ones instead of rolling over.
  assign w_count_next      = (&r_taken_count) ? r_taken_count
                                              : r_taken_count + 16'd1;

  // Sequencer FSM: state, fetch address, status flags and redirect counter.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_pc_valid    <= 1'b0;
      r_flush       <= 1'b0;
      r_halted      <= 1'b0;
      r_taken_count <= '0;
      r_flush_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (en) begin
            if (halt) begin
              // Kill anything younger for one cycle, then park.
              r_state     <= ST_HALT;
              r_pc_valid  <= 1'b0;
              r_flush     <= 1'b1;
              r_halted    <= 1'b1;
              r_flush_cnt <= '0;
            end else if (!r_pc_valid) begin
              // First advancing edge after reset: fetch at RESET_PC
              // becomes valid without stepping the address.
              r_pc_valid  <= 1'b1;
            end else if (w_redirect) begin
              r_state       <= ST_FLUSH;
              r_pc          <= w_redirect_target;
              r_pc_valid    <= 1'b0;
              r_flush       <= 1'b1;
              r_flush_cnt   <= FLUSH_LOAD;
              r_taken_count <= w_count_next;
            end else begin
              // Sequential fetch; a not-taken branch lands here too.
              r_pc        <= w_pc_inc;
              r_pc_valid  <= 1'b1;
              r_flush     <= 1'b0;
            end
          end
        end

        ST_FLUSH: begin
          // Branches and jumps seen here belong to squashed instructions.
          if (en) begin
            if (halt) begin
              r_state     <= ST_HALT;
              r_pc_valid  <= 1'b0;
              r_flush     <= 1'b1;
              r_halted    <= 1'b1;
              r_flush_cnt <= '0;
            end else if (r_flush_cnt == 2'd0) begin
              // Bubble window over: first valid fetch is at the target.
              r_state     <= ST_RUN;
              r_pc_valid  <= 1'b1;
              r_flush     <= 1'b0;
            end else begin
              r_flush_cnt <= r_flush_cnt - 2'd1;
            end
          end
        end

        ST_HALT: begin
          // Sticky until reset; only the entry flush pulse is retired.
          r_flush <= 1'b0;
        end

        default: begin
          r_state    <= ST_HALT;
          r_pc_valid <= 1'b0;
          r_flush    <= 1'b0;
          r_halted   <= 1'b1;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign pc_valid    = r_pc_valid;
  assign flush       = r_flush;
  assign halted      = r_halted;
  assign taken_count = r_taken_count;

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
// tb_pc_sequencer
// Scoreboard bench: the driver applies stimulus on the falling edge, steps a
// behavioural model of the sequencer and queues the expected outputs; a
// separate monitor pops and compares just after each rising edge. Two DUTs
// share the stimulus, one with a single bubble and one with three.

module tb_pc_sequencer;

  localparam int AW = 20;

  typedef struct packed {
    logic          en;
    logic          bv;
    logic          bt;
    logic [AW-1:0] btg;
    logic          jv;
    logic [AW-1:0] jt;
    logic          halt;
  } stim_t;

  // Model state: "bubbles" is the number of advancing cycles still to pass
  // before fetch becomes valid again after a redirect.
  typedef struct {
    logic [AW-1:0] pc;
    bit            valid;
    bit            flush;
    bit            halted;
    bit            primed;
    int            bubbles;
    int            count;
  } mstate_t;

  logic          clk;
  logic          rst_n;
  logic          en, br_valid, br_taken, jmp_valid, halt;
  logic [AW-1:0] br_target, jmp_target;

  logic [AW-1:0] pc1, pc3;
  logic          pv1, pv3, fl1, fl3, hl1, hl3;
  logic [15:0]   cnt1, cnt3;

  logic [38:0]   q1[$];
  logic [38:0]   q3[$];
  mstate_t       m1, m3;
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            started  = 0;

  pc_sequencer #(.ADDR_W(AW), .RESET_PC('0), .FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .halt(halt),
    .pc(pc1), .pc_valid(pv1), .flush(fl1), .halted(hl1), .taken_count(cnt1)
  );

  pc_sequencer #(.ADDR_W(AW), .RESET_PC('0), .FLUSH_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .halt(halt),
    .pc(pc3), .pc_valid(pv3), .flush(fl3), .halted(hl3), .taken_count(cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic mstate_t model_reset();
    mstate_t n;
    n.pc = '0; n.valid = 0; n.flush = 0; n.halted = 0;
    n.primed = 0; n.bubbles = 0; n.count = 0;
    return n;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input stim_t in, input int fc);
    mstate_t n;
    n = s;
    if (s.halted) begin
      n.flush = 0;                       // halted: everything else frozen
    end else if (in.en) begin
      if (in.halt) begin
        n.halted = 1; n.valid = 0; n.flush = 1; n.bubbles = 0;
      end else if (s.bubbles > 0) begin
        n.bubbles = s.bubbles - 1;       // redirect inputs are squashed here
        if (n.bubbles == 0) begin
          n.valid = 1; n.flush = 0;
        end
      end else if (!s.primed) begin
        n.primed = 1; n.valid = 1;
      end else if ((in.bv && in.bt) || in.jv) begin
        n.pc      = (in.bv && in.bt) ? in.btg : in.jt;
        n.bubbles = fc;
        n.valid   = 0;
        n.flush   = 1;
        if (s.count < 65535) n.count = s.count + 1;
      end else begin
        n.pc    = AW'((int'(s.pc) + 1) % (1 << AW));
        n.valid = 1;
        n.flush = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [38:0] pack(input mstate_t m);
    logic [15:0] c;
    c = 16'(m.count);
    return {m.pc, m.valid, m.flush, m.halted, c};
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else
      $display("FAIL %s @%0t: got pc=%h valid=%b flush=%b halted=%b cnt=%0d, expected pc=%h valid=%b flush=%b halted=%b cnt=%0d",
               name, $time, act[38:19], act[18], act[17], act[16], act[15:0],
               exp[38:19], exp[18], exp[17], exp[16], exp[15:0]);
  endtask

  // ---------------- driver helpers ----------------
  function automatic stim_t mk(input logic e, input logic bv, input logic bt,
                               input logic [AW-1:0] btg, input logic jv,
                               input logic [AW-1:0] jt, input logic h);
    stim_t s;
    s.en = e; s.bv = bv; s.bt = bt; s.btg = btg; s.jv = jv; s.jt = jt; s.halt = h;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    en = s.en; br_valid = s.bv; br_taken = s.bt; br_target = s.btg;
    jmp_valid = s.jv; jmp_target = s.jt; halt = s.halt;
  endtask

  task automatic cyc(input stim_t s);
    @(negedge clk);
    rst_n = 1'b1;
    apply(s);
    m1 = model_step(m1, s, 1);
    m3 = model_step(m3, s, 3);
    q1.push_back(pack(m1));
    q3.push_back(pack(m3));
    started = 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(mk(1, 0, 0, '0, 0, '0, 0));
  endtask

  task automatic reset_cycle(input bit check_now);
    @(negedge clk);
    rst_n = 1'b0;
    apply(mk(1, 0, 0, '0, 0, '0, 0));
    m1 = model_reset();
    m3 = model_reset();
    if (check_now) begin
      #1;
      check("async_reset_fc1", {pc1, pv1, fl1, hl1, cnt1}, pack(m1));
      check("async_reset_fc3", {pc3, pv3, fl3, hl3, cnt3}, pack(m3));
    end
    q1.push_back(pack(m1));
    q3.push_back(pack(m3));
    started = 1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    wait (started);
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() == 0 || q3.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow @%0t: got queue sizes %0d/%0d, expected nonempty",
                 $time, q1.size(), q3.size());
      end else begin
        check("dut_fc1", {pc1, pv1, fl1, hl1, cnt1}, q1.pop_front());
        check("dut_fc3", {pc3, pv3, fl3, hl3, cnt3}, q3.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected end of run");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    rst_n = 1'b0;
    apply(mk(0, 0, 0, '0, 0, '0, 0));
    m1 = model_reset();
    m3 = model_reset();

    reset_cycle(1);
    reset_cycle(0);

    // Reset release and straight-line fetch: 0,1,2,3.
    idle(4);

    // Taken branch at pc=5.
    for (int k = 0; k < 20 && !(m1.valid && m1.pc == 5); k++) idle(1);
    cyc(mk(1, 1, 1, 20'd111, 0, '0, 0));
    idle(5);

    // Jump when a not-taken branch resolves alongside it, at pc=8.
    cyc(mk(1, 0, 0, '0, 1, 20'd8, 0));
    for (int k = 0; k < 20 && !(m1.valid && m1.pc == 8); k++) idle(1);
    cyc(mk(1, 1, 0, 20'd77, 1, 20'd49, 0));
    idle(4);

    // Taken branch beats a simultaneous jump.
    cyc(mk(1, 0, 0, '0, 1, 20'd8, 0));
    for (int k = 0; k < 20 && !(m1.valid && m1.pc == 8); k++) idle(1);
    cyc(mk(1, 1, 1, 20'd50, 1, 20'd49, 0));
    idle(4);

    // Wrap from all-ones to zero, then a three-cycle stall.
    cyc(mk(1, 0, 0, '0, 1, 20'hFFFFF, 0));
    for (int k = 0; k < 20 && !(m1.valid && m1.pc == 0); k++) idle(1);
    idle(1);
    for (int k = 0; k < 3; k++) cyc(mk(0, 1, 1, 20'd3, 1, 20'd4, 0));
    idle(2);

    // Bubble window with en toggling 1,0,1,1.
    idle(4);
    cyc(mk(1, 1, 1, 20'd300, 0, '0, 0));
    cyc(mk(1, 0, 0, '0, 0, '0, 0));
    cyc(mk(0, 0, 0, '0, 0, '0, 0));
    cyc(mk(1, 0, 0, '0, 0, '0, 0));
    cyc(mk(1, 0, 0, '0, 0, '0, 0));
    idle(2);

    // Halt during the bubble window, later redirects ignored, then reset.
    idle(4);
    cyc(mk(1, 1, 1, 20'd500, 0, '0, 0));
    cyc(mk(1, 0, 0, '0, 0, '0, 1));
    cyc(mk(1, 1, 1, 20'd600, 0, '0, 0));
    cyc(mk(1, 0, 0, '0, 1, 20'd700, 0));
    cyc(mk(0, 0, 0, '0, 0, '0, 1));
    idle(2);
    reset_cycle(1);
    idle(3);

    // Reset in the middle of a bubble window leaves no flush behind.
    cyc(mk(1, 1, 1, 20'd900, 0, '0, 0));
    reset_cycle(1);
    idle(3);

    // Halt from straight-line fetch.
    cyc(mk(1, 0, 0, '0, 0, '0, 1));
    idle(3);
    reset_cycle(0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset_cycle($urandom_range(0, 1) == 1);
      end else begin
        s.en   = ($urandom_range(0, 4) != 0);
        s.bv   = ($urandom_range(0, 3) == 0);
        s.bt   = 1'($urandom_range(0, 1));
        s.btg  = AW'($urandom);
        s.jv   = ($urandom_range(0, 6) == 0);
        s.jt   = AW'($urandom);
        s.halt = ($urandom_range(0, 49) == 0);
        cyc(s);
      end
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (q1.size() == 0 && q3.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d/%0d left, expected 0/0", q1.size(), q3.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
